// File: rtl/ena_pulse_gen.sv
// Clock-enable strobe generator: cascaded decimal prescaler on the falling edge of ckht
// producing aligned 1 kHz .. 1 Hz single-cycle strobes and a 1 Hz blink level.
module ena_pulse_gen #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic ckht,
   input  logic rst_n,
   input  logic run,
   input  logic sclr,
   output logic ena1khz,
   output logic ena100hz,
   output logic ena10hz,
   output logic ena2hz,
   output logic ena1hz,
   output logic blink1hz
);

   localparam int DIV0 = CLK_HZ / 1000;
   localparam int W0   = $clog2(DIV0);
   localparam logic [W0-1:0] CNT0_MAX = W0'(DIV0 - 1);

   logic [W0-1:0] cnt0, cnt0_nxt;
   logic [3:0]    cnt1, cnt1_nxt;
   logic [3:0]    cnt2, cnt2_nxt;
   logic [3:0]    cnt3, cnt3_nxt;
   logic          blink, blink_nxt;

   // Each slower strobe is gated by the faster one, so they always coincide.
   assign ena1khz  = run & (cnt0 == CNT0_MAX);
   assign ena100hz = ena1khz & (cnt1 == 4'd9);
   assign ena10hz  = ena100hz & (cnt2 == 4'd9);
   assign ena1hz   = ena10hz & (cnt3 == 4'd9);
   assign ena2hz   = ena10hz & ((cnt3 == 4'd4) | (cnt3 == 4'd9));
   assign blink1hz = blink;

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path can infer a latch.
      cnt0_nxt  = cnt0;
      cnt1_nxt  = cnt1;
      cnt2_nxt  = cnt2;
      cnt3_nxt  = cnt3;
      blink_nxt = blink;
      if (sclr) begin
         cnt0_nxt  = '0;
         cnt1_nxt  = '0;
         cnt2_nxt  = '0;
         cnt3_nxt  = '0;
         blink_nxt = 1'b0;
      end else if (run) begin
         cnt0_nxt = (cnt0 == CNT0_MAX) ? '0 : cnt0 + W0'(1);
         if (ena1khz)  cnt1_nxt  = (cnt1 == 4'd9) ? 4'd0 : cnt1 + 4'd1;
         if (ena100hz) cnt2_nxt  = (cnt2 == 4'd9) ? 4'd0 : cnt2 + 4'd1;
         if (ena10hz)  cnt3_nxt  = (cnt3 == 4'd9) ? 4'd0 : cnt3 + 4'd1;
         if (ena2hz)   blink_nxt = ~blink;
      end
   end

   // NOTE: every register here is control state with a defined reset value; none is skipped.
   always_ff @(negedge ckht or negedge rst_n) begin
      if (!rst_n) begin
         cnt0  <= '0;
         cnt1  <= '0;
         cnt2  <= '0;
         cnt3  <= '0;
         blink <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
         cnt0  <= cnt0_nxt;
         cnt1  <= cnt1_nxt;
         cnt2  <= cnt2_nxt;
         cnt3  <= cnt3_nxt;
         blink <= blink_nxt;
      end
   end

endmodule

// File: doc/ena_pulse_gen.md
Name: ena_pulse_gen

Overview:
Clock-enable pulse generator that produces the single-cycle rate strobes (ena1khz and slower) consumed by the counter and display blocks. It is clocked by the board clock ckht. It divides ckht by a cascaded prescaler chain, so every slower strobe coincides with a faster one. It also provides a 1 Hz 50%-duty blink level for display use.

Parameters:
CLK_HZ, 50_000_000, ckht frequency in Hz. Must be an integer multiple of 1000 and ≥ 2000.
DIV0, CLK_HZ/1000 (localparam), ckht cycles per 1 kHz strobe. The stage-0 counter width is $clog2(DIV0).

Ports:
ckht      input   1  system clock; all state updates on the falling edge of ckht
rst_n     input   1  asynchronous reset, active-low
run       input   1  1 = prescaler advances; 0 = all counters frozen and all strobes forced 0
sclr      input   1  synchronous clear of the whole chain; has priority over run
ena1khz   output  1  one-ckht-cycle strobe, period DIV0 cycles
ena100hz  output  1  one-cycle strobe, period 10*DIV0 cycles
ena10hz   output  1  one-cycle strobe, period 100*DIV0 cycles
ena2hz    output  1  one-cycle strobe, period 500*DIV0 cycles
ena1hz    output  1  one-cycle strobe, period 1000*DIV0 cycles
blink1hz  output  1  level output that toggles on each ena2hz strobe (1 Hz square wave)

Behaviour:
- Reset: rst_n=0 forces cnt0, cnt1, cnt2 and cnt3 to 0 and blink1hz to 0 immediately, independent of ckht. All strobes are 0 while rst_n=0.
- Registers: cnt0 counts 0..DIV0-1. cnt1, cnt2 and cnt3 each count 0..9. blink is a 1-bit register. All are negedge ckht flops.
- Strobe decode is combinational from the registers and run:
  - ena1khz = run & (cnt0==DIV0-1)
  - ena100hz = ena1khz & (cnt1==9)
  - ena10hz = ena100hz & (cnt2==9)
  - ena1hz = ena10hz & (cnt3==9)
  - ena2hz = ena10hz & (cnt3==4 | cnt3==9)
- Next state, in priority order:
  - sclr=1: all counters and blink go to 0. Strobes are still decoded during that cycle.
  - else run=0: hold all state.
  - else: cnt0 wraps DIV0-1→0, otherwise increments. cnt1 advances (9→0 wrap) only when ena1khz=1. cnt2 advances only when ena100hz=1. cnt3 advances only when ena10hz=1. blink inverts when ena2hz=1.
- Timing from a clean start (reset or sclr released, run=1):
  - ena1khz is first high in the cycle after DIV0-1 falling edges.
  - Thereafter ena1khz is high exactly 1 cycle in every DIV0; no two consecutive cycles are high.
  - Slower strobes are aligned: each occurs only in a cycle where all faster strobes are also high.
- run deasserted mid-count: the counts are kept. On resume, the remaining phase continues without loss; the total active-cycle count between strobes is still DIV0.
- sclr and run both 1: clear wins.
- rst_n asserted mid-operation: immediate clear. Behaviour after release is identical to power-up.
- blink1hz is registered and changes on the falling edge that ends an ena2hz cycle.

Test Plan:
- CLK_HZ=10_000 (DIV0=10), rst_n released, run=1 for 12000 cycles:
  - first ena1khz at cycle 10, then every 10 cycles.
  - ena100hz every 100, ena10hz every 1000, ena2hz every 5000, ena1hz every 10000.
  - every strobe is exactly 1 cycle wide.
- Same run: blink1hz = 0 for cycles 0..5000, 1 after the first ena2hz, 0 after the second. Measured period is 10000 cycles, 50% duty.
- run=0 for 37 cycles starting at cnt0=4:
  - all strobes stay 0 throughout.
  - after run=1, next ena1khz appears 5 active cycles later; the 1 kHz phase is otherwise unchanged.
- sclr pulsed 1 cycle at cnt3=6, cnt0=3:
  - all counters read 0 afterwards; blink1hz=0.
  - next ena1khz appears 10 cycles after release; next ena1hz appears 10000 cycles after release.
- rst_n pulled low between clock edges in the middle of the count: outputs are 0 without waiting for a ckht edge; post-release timing matches the first scenario.
- Checker: assert ena1hz→ena10hz→ena100hz→ena1khz implication every cycle; assert no strobe is high for 2 consecutive cycles.
